// File: rtl/core_pkg.sv
// Shared encodings for the decode/execute boundary: operand selects,
// function-code build classes and ALU function constants.
package core_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    ASEL_RS1  = 2'd0,
    ASEL_PC   = 2'd1,
    ASEL_ZERO = 2'd2
  } asel_e;

  typedef enum logic [1:0] {
    BSEL_RS2  = 2'd0,
    BSEL_IMM  = 2'd1,
    BSEL_FOUR = 2'd2
  } bsel_e;

  typedef enum logic [1:0] {
    FCLASS_RTYPE = 2'd0,
    FCLASS_ITYPE = 2'd1,
    FCLASS_ADD   = 2'd2
  } fclass_e;

  localparam logic [9:0] FUNC_ADD  = 10'b0000000_000;
  localparam logic [9:0] FUNC_SUB  = 10'b0100000_000;
  localparam logic [9:0] FUNC_SLL  = 10'b0000000_001;
  localparam logic [9:0] FUNC_SLT  = 10'b0000000_010;
  localparam logic [9:0] FUNC_SLTU = 10'b0000000_011;
  localparam logic [9:0] FUNC_XOR  = 10'b0000000_100;
  localparam logic [9:0] FUNC_SRL  = 10'b0000000_101;
  localparam logic [9:0] FUNC_SRA  = 10'b0100000_101;
  localparam logic [9:0] FUNC_OR   = 10'b0000000_110;
  localparam logic [9:0] FUNC_AND  = 10'b0000000_111;

endpackage

// File: rtl/fwd_mux.sv
// Resolves one source operand: MEM result beats WB result beats the stored
// register-file value; x0 always reads zero.
module fwd_mux #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rs,
  input  logic [XLEN-1:0]   i_data,
  input  logic              i_mem_wen,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic [XLEN-1:0]   i_mem_data,
  input  logic              i_wb_wen,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic [XLEN-1:0]   i_wb_data,
  output logic [XLEN-1:0]   o_data
);

  always_comb begin
    o_data = i_data;
    if (i_rs == '0)
      o_data = '0;
    else if (i_mem_wen && (i_mem_rd == i_rs))
      o_data = i_mem_data;
    else if (i_wb_wen && (i_wb_rd == i_rs))
      o_data = i_wb_data;
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, ALU function-code
// build and load-use hazard detection for one issue lane.
module alu_operand_stage #(
  parameter int unsigned XLEN   = core_pkg::XLEN,
  parameter int unsigned REG_AW = core_pkg::REG_AW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [1:0]        id_a_sel_i,
  input  logic [1:0]        id_b_sel_i,
  input  logic [1:0]        id_fclass_i,
  input  logic [2:0]        id_funct3_i,
  input  logic [6:0]        id_funct7_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_wen_i,
  input  logic              id_is_load_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              mem_wen_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic              wb_wen_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic              ex_valid_o,
  output logic [XLEN-1:0]   ex_a_o,
  output logic [XLEN-1:0]   ex_b_o,
  output logic [9:0]        ex_func_o,
  output logic [XLEN-1:0]   ex_rs2_fwd_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic              ex_wen_o,
  output logic              ex_is_load_o,
  output logic              load_use_o
);
  import core_pkg::*;

  logic              r_valid;
  logic [REG_AW-1:0] r_rs1, r_rs2, r_rd;
  logic [XLEN-1:0]   r_rs1_data, r_rs2_data, r_imm, r_pc;
  asel_e             r_a_sel;
  bsel_e             r_b_sel;
  logic [9:0]        r_func;
  logic              r_wen, r_is_load;

  logic [XLEN-1:0]   w_rs1_fwd, w_rs2_fwd;
  logic [XLEN-1:0]   w_rs1_wt, w_rs2_wt;
  logic [9:0]        w_func_next;
  logic [XLEN-1:0]   w_a, w_b;

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .i_rs(r_rs1), .i_data(r_rs1_data),
    .i_mem_wen(mem_wen_i), .i_mem_rd(mem_rd_i), .i_mem_data(mem_data_i),
    .i_wb_wen(wb_wen_i), .i_wb_rd(wb_rd_i), .i_wb_data(wb_data_i),
    .o_data(w_rs1_fwd)
  );

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .i_rs(r_rs2), .i_data(r_rs2_data),
    .i_mem_wen(mem_wen_i), .i_mem_rd(mem_rd_i), .i_mem_data(mem_data_i),
    .i_wb_wen(wb_wen_i), .i_wb_rd(wb_rd_i), .i_wb_data(wb_data_i),
    .o_data(w_rs2_fwd)
  );

  // Write-through: a WB result retiring in the capture cycle is missed by the register-file read.
  assign w_rs1_wt = (wb_wen_i && (wb_rd_i == id_rs1_i) && (id_rs1_i != '0)) ? wb_data_i : id_rs1_data_i;
  assign w_rs2_wt = (wb_wen_i && (wb_rd_i == id_rs2_i) && (id_rs2_i != '0)) ? wb_data_i : id_rs2_data_i;

  always_comb begin
    w_func_next = FUNC_ADD;
    case (fclass_e'(id_fclass_i))
      FCLASS_RTYPE: w_func_next = {id_funct7_i, id_funct3_i};
      FCLASS_ITYPE: w_func_next = (id_funct3_i == 3'b101) ? {id_imm_i[11:5], 3'b101}
                                                          : {7'b0, id_funct3_i};
      default:      w_func_next = FUNC_ADD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid    <= 1'b0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_pc       <= '0;
      r_a_sel    <= ASEL_RS1;
      r_b_sel    <= BSEL_RS2;
      r_func     <= FUNC_ADD;
      r_wen      <= 1'b0;
      r_is_load  <= 1'b0;
    end else if (flush_i) begin
      r_valid   <= 1'b0;
      r_wen     <= 1'b0;
      r_is_load <= 1'b0;
    end else if (stall_i) begin
      r_rs1_data <= w_rs1_fwd;
      r_rs2_data <= w_rs2_fwd;
    end else begin
      r_valid    <= id_valid_i;
      r_rs1      <= id_rs1_i;
      r_rs2      <= id_rs2_i;
      r_rd       <= id_rd_i;
      r_rs1_data <= w_rs1_wt;
      r_rs2_data <= w_rs2_wt;
      r_imm      <= id_imm_i;
      r_pc       <= id_pc_i;
      r_a_sel    <= asel_e'(id_a_sel_i);
      r_b_sel    <= bsel_e'(id_b_sel_i);
      r_func     <= w_func_next;
      r_wen      <= id_wen_i;
      r_is_load  <= id_is_load_i;
    end
  end

  always_comb begin
    w_a = '0;
    case (r_a_sel)
      ASEL_RS1: w_a = w_rs1_fwd;
      ASEL_PC:  w_a = r_pc;
      default:  w_a = '0;
    endcase
  end

  always_comb begin
    w_b = '0;
    case (r_b_sel)
      BSEL_RS2:  w_b = w_rs2_fwd;
      BSEL_IMM:  w_b = r_imm;
      BSEL_FOUR: w_b = XLEN'(4);
      default:   w_b = '0;
    endcase
  end

  assign ex_valid_o   = r_valid;
  assign ex_a_o       = w_a;
  assign ex_b_o       = w_b;
  assign ex_func_o    = r_func;
  assign ex_rs2_fwd_o = w_rs2_fwd;
  assign ex_rd_o      = r_rd;
  assign ex_wen_o     = r_wen;
  assign ex_is_load_o = r_is_load;
  assign load_use_o   = r_valid && r_is_load && (r_rd != '0) &&
                        ((r_rd == id_rs1_i) || (r_rd == id_rs2_i));

endmodule
